// File: rtl/seq_gen.sv
// seq_gen: programmable WIDTH-bit value source with four modes: constant, wrapping ramp, saturating ramp and periodic ramp.
// Latency: every output is registered, and the first valid value appears one cycle after reset/init drops.
// Backpressure: none. seq_gen_in_disable freezes all state. Optional down-count port under `SEQ_GEN_DOWN_EN.
module seq_gen #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RST_VALUE = '0
) (
    input  logic             seq_gen_clk,
    input  logic             seq_gen_reset,
    input  logic             seq_gen_init,
    input  logic             seq_gen_in_disable,
    input  logic [1:0]       seq_gen_in_mode,
    input  logic [WIDTH-1:0] seq_gen_in_start,
    input  logic [WIDTH-1:0] seq_gen_in_step,
    input  logic [WIDTH-1:0] seq_gen_in_end,
`ifdef SEQ_GEN_DOWN_EN
    input  logic             seq_gen_in_dir,
`endif
    output logic [WIDTH-1:0] seq_gen_out_value,
    output logic             seq_gen_out_valid,
    output logic             seq_gen_out_last,
    output logic             seq_gen_out_done
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_WRAP  = 2'd1;
    localparam logic [1:0] MODE_SAT   = 2'd2;
    localparam logic [1:0] MODE_PER   = 2'd3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             last_q,  last_d;
    logic             done_q,  done_d;

    logic             reset_i;
    logic             dir_w;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] next_w;
    logic             wrap_w;
    logic             term_w;

    assign reset_i = seq_gen_reset | seq_gen_init;

`ifdef SEQ_GEN_DOWN_EN
    assign dir_w = seq_gen_in_dir;
`else
    assign dir_w = 1'b0;
`endif

    // Compute the step arithmetic and the terminal test for the active direction.
    always_comb begin
        sum_w  = {1'b0, value_q} + {1'b0, seq_gen_in_step};
        diff_w = {1'b0, value_q} - {1'b0, seq_gen_in_step};
        if (dir_w) begin
            next_w = diff_w[WIDTH-1:0];
            // The top bit of the extended difference is the borrow out of the subtraction.
            wrap_w = diff_w[WIDTH];
            term_w = (value_q <= seq_gen_in_end) ||
                     ((value_q - seq_gen_in_end) < seq_gen_in_step);
        end else begin
            next_w = sum_w[WIDTH-1:0];
            wrap_w = sum_w[WIDTH];
            // Checking the remaining distance avoids overflow when value+step would pass end.
            term_w = (value_q >= seq_gen_in_end) ||
                     ((seq_gen_in_end - value_q) < seq_gen_in_step);
        end
    end

    // Compute next state and outputs. Priority: reset/init, then disable, then the mode logic.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        valid_d = valid_q;
        last_d  = 1'b0;
        done_d  = done_q;
        if (reset_i) begin
            state_d = ST_LOAD;
            value_d = RST_VALUE;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (seq_gen_in_disable) begin
            last_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    value_d = seq_gen_in_start;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    case (seq_gen_in_mode)
                        MODE_CONST: value_d = seq_gen_in_start;
                        MODE_WRAP: begin
                            value_d = next_w;
                            last_d  = wrap_w;
                        end
                        MODE_SAT: begin
                            if (term_w) begin
                                value_d = seq_gen_in_end;
                                last_d  = 1'b1;
                                done_d  = 1'b1;
                                state_d = ST_HOLD;
                            end else begin
                                value_d = next_w;
                            end
                        end
                        MODE_PER: begin
                            if (term_w) begin
                                value_d = seq_gen_in_start;
                                last_d  = 1'b1;
                            end else begin
                                value_d = next_w;
                            end
                        end
                        default: value_d = value_q;
                    endcase
                end
                ST_HOLD: begin
                    // Leaving saturation keeps the value for one edge, and the new mode applies on the following edge.
                    if (seq_gen_in_mode != MODE_SAT) begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge seq_gen_clk) begin
        state_q <= state_d;
        value_q <= value_d;
        valid_q <= valid_d;
        last_q  <= last_d;
        done_q  <= done_d;
    end

    assign seq_gen_out_value = value_q;
    assign seq_gen_out_valid = valid_q;
    assign seq_gen_out_last  = last_q;
    assign seq_gen_out_done  = done_q;

endmodule
